sci_host_link: RTL and testbench

- Host-side UART protocol engine: the initiator end of the NN core's serial link.
- Takes a parallel input vector, frames it as bytes and drives them into a byte-level UART transmitter.
- Then collects the NN core's result frame from a byte-level UART receiver and presents it as a parallel word.
- Lets a second FPGA, or a loopback test harness, drive the NN core over rxd/txd without a PC.

---
 rtl/sci_host_link.sv | 190 +++++++++++++++++++
 tb/tb_sci_host_link.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sci_host_link.sv
// rtl/sci_host_link.sv - host-side UART protocol engine driving the NN core serial link
`timescale 1ns/1ps
module sci_host_link #(
  parameter int         I_NUM   = 16,
  parameter int         O_NUM   = 32,
  parameter int         TIMEOUT = 1000000,
  parameter logic [7:0] HDR_TX  = 8'hA5,
  parameter logic [7:0] HDR_RX  = 8'h5A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [I_NUM-1:0] a_vec,
  output logic             busy,
  output logic             done,
  output logic [O_NUM-1:0] result,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  input  logic             rx_error
);
  localparam int IB  = (I_NUM + 7) / 8;
  localparam int OB  = (O_NUM + 7) / 8;
  localparam int NB  = (IB > OB) ? IB : OB;
  localparam int BCW = $clog2(NB + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TX_HDR, S_TX_ACK, S_TX_IDLE, S_TX_BYTE,
    S_RX_HDR, S_RX_BYTE, S_DONE, S_ERROR
  } state_t;

  state_t           state, state_n;
  logic [IB*8-1:0]  sh, sh_n;
  logic [OB*8-1:0]  rbuf, rbuf_n;
  logic [BCW-1:0]   byte_cnt, byte_cnt_n;
  logic [TCW-1:0]   tcnt, tcnt_n;
  logic             rdy_s, rdy_p, rer_s, rer_p;
  logic [7:0]       rx_dq;
  logic             busy_n, done_n, err_n, tx_start_n;
  logic [1:0]       err_code_n;
  logic [7:0]       tx_data_n;
  logic [O_NUM-1:0] result_n;
  logic             rdy_ev, rer_ev, rx_last, to_hit;

  // rx flags and data are registered together so an event sees the byte that raised it
  assign rdy_ev  = rdy_s & ~rdy_p;
  assign rer_ev  = rer_s & ~rer_p;
  assign rx_last = (byte_cnt == BCW'(OB - 1));
  assign to_hit  = (tcnt == TCW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sh       <= '0;
      rbuf     <= '0;
      byte_cnt <= '0;
      tcnt     <= '0;
      rdy_s    <= 1'b0;
      rdy_p    <= 1'b0;
      rer_s    <= 1'b0;
      rer_p    <= 1'b0;
      rx_dq    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      result   <= '0;
    end else begin
      state    <= state_n;
      sh       <= sh_n;
      rbuf     <= rbuf_n;
      byte_cnt <= byte_cnt_n;
      tcnt     <= tcnt_n;
      rdy_s    <= rx_ready;
      rdy_p    <= rdy_s;
      rer_s    <= rx_error;
      rer_p    <= rer_s;
      rx_dq    <= rx_data;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      err_code <= err_code_n;
      tx_data  <= tx_data_n;
      tx_start <= tx_start_n;
      result   <= result_n;
    end
  end

  always_comb begin
    state_n    = state;
    sh_n       = sh;
    rbuf_n     = rbuf;
    byte_cnt_n = byte_cnt;
    tcnt_n     = tcnt;
    busy_n     = busy;
    done_n     = 1'b0;
    err_n      = 1'b0;
    err_code_n = err_code;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
    result_n   = result;
    case (state)
      S_IDLE: begin
        if (req) begin
          sh_n              = '0;
          sh_n[I_NUM-1:0]   = a_vec;
          busy_n            = 1'b1;
          err_code_n        = 2'd0;
          byte_cnt_n        = '0;
          state_n           = S_TX_HDR;
        end
      end
      S_TX_HDR: begin
        if (tx_ready) begin
          tx_data_n  = HDR_TX;
          tx_start_n = 1'b1;
          state_n    = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        if (!tx_ready) state_n = S_TX_IDLE;
      end
      S_TX_IDLE: begin
        if (tx_ready) begin
          if (byte_cnt < BCW'(IB)) begin
            state_n = S_TX_BYTE;
          end else begin
            byte_cnt_n = '0;
            tcnt_n     = '0;
            state_n    = S_RX_HDR;
          end
        end
      end
      S_TX_BYTE: begin
        tx_data_n  = sh[7:0];
        tx_start_n = 1'b1;
        sh_n       = sh >> 8;
        byte_cnt_n = byte_cnt + BCW'(1);
        state_n    = S_TX_ACK;
      end
      S_RX_HDR: begin
        if (rer_ev) begin
          err_n = 1'b1; err_code_n = 2'd2; state_n = S_ERROR;
        end else if (rdy_ev) begin
          if (rx_dq == HDR_RX) begin
            tcnt_n  = '0;
            state_n = S_RX_BYTE;
          end else begin
            err_n = 1'b1; err_code_n = 2'd3; state_n = S_ERROR;
          end
        end else if (to_hit) begin
          err_n = 1'b1; err_code_n = 2'd1; state_n = S_ERROR;
        end else begin
          tcnt_n = tcnt + TCW'(1);
        end
      end
      S_RX_BYTE: begin
        if (rer_ev) begin
          err_n = 1'b1; err_code_n = 2'd2; state_n = S_ERROR;
        end else if (rdy_ev) begin
          for (int i = 0; i < OB; i++)
            if (byte_cnt == BCW'(i)) rbuf_n[i*8 +: 8] = rx_dq;
          byte_cnt_n = byte_cnt + BCW'(1);
          tcnt_n     = '0;
          if (rx_last) begin
            result_n = rbuf_n[O_NUM-1:0];
            done_n   = 1'b1;
            state_n  = S_DONE;
          end
        end else if (to_hit) begin
          err_n = 1'b1; err_code_n = 2'd1; state_n = S_ERROR;
        end else begin
          tcnt_n = tcnt + TCW'(1);
        end
      end
      S_DONE, S_ERROR: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_sci_host_link.sv
// tb/tb_sci_host_link.sv - table-driven and randomized bench for sci_host_link
`timescale 1ns/1ps
module tb_sci_host_link;
  localparam int TO = 100;
  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [15:0] a_vec = '0;
  logic        busy, done, err, tx_start;
  logic [31:0] result;
  logic [1:0]  err_code;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_ready = 1'b0;
  logic        rx_error = 1'b0;

  sci_host_link #(.I_NUM(16), .O_NUM(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_vec(a_vec),
    .busy(busy), .done(done), .result(result), .err(err), .err_code(err_code),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [39:0] rsp;       // reply byte i at rsp[8*i +: 8]
    int          nrsp;
    int          err_at;    // reply index carrying rx_error, -1 for none
    bit          err_only;  // rx_error without rx_ready on that slot
    bit          exp_done;
    logic [1:0]  exp_code;
    logic [31:0] exp_res;
  } vec_t;

  vec_t tbl [NV];

  int n_chk = 0, n_bad = 0, cyc = 0;
  int tx_hold = 3, tx_cnt = 0, tx_idle = 0, hs_viol = 0;
  logic [7:0] tx_log [$];
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, raise_cyc = 0;
  bit prev_done = 0, busy_at_done = 0, busy_after_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // transmitter: drops tx_ready for tx_hold cycles after every launch
  always @(negedge clk) begin
    if (tx_start) begin
      tx_log.push_back(tx_data);
      if (!tx_ready) hs_viol <= hs_viol + 1;
      tx_ready <= 1'b0;
      tx_cnt   <= tx_hold;
      tx_idle  <= 0;
    end else if (!tx_ready) begin
      tx_idle <= 0;
      if (tx_cnt <= 1) tx_ready <= 1'b1;
      else tx_cnt <= tx_cnt - 1;
    end else begin
      tx_idle <= tx_idle + 1;
    end
  end

  always @(negedge clk) begin
    prev_done <= done;
    if (prev_done) busy_after_done <= busy;
    if (done) begin done_cnt <= done_cnt + 1; busy_at_done <= busy; end
    if (err) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: walk the reply bytes with the protocol rules
  function automatic void model(input logic [39:0] rsp, input int nrsp, input int err_at,
                                input logic [31:0] prev, output bit d,
                                output logic [1:0] code, output logic [31:0] res);
    logic [31:0] acc;
    logic [7:0]  b;
    acc = '0; d = 0; code = 2'd1; res = prev;
    for (int i = 0; i < nrsp; i++) begin
      b = rsp[8*i +: 8];
      if (i == err_at) begin code = 2'd2; return; end
      if (i == 0) begin
        if (b != 8'h5A) begin code = 2'd3; return; end
      end else begin
        acc = acc | (32'(b) << (8 * (i - 1)));
        if (i == 4) begin d = 1; code = 2'd0; res = acc; return; end
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit with_err, input bit err_only);
    @(negedge clk);
    rx_data   = b;
    rx_ready  = !(with_err && err_only);
    rx_error  = with_err;
    raise_cyc = cyc;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_error = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_txn(input logic [15:0] a, input bit poke);
    int t;
    tx_log.delete();
    @(negedge clk);
    chk("idle_before_req", busy, 0);
    req = 1'b1; a_vec = a;
    @(negedge clk);
    req = 1'b0;
    chk("busy_on_accept", busy, 1);
    chk("tx_start_lat1", tx_start, 0);
    @(negedge clk);
    chk("tx_start_lat2", tx_start, 1);
    chk("tx_hdr_now", tx_data, 8'hA5);
    t = 0;
    while (!(tx_log.size() == 3 && tx_idle >= 3) && t < 2000) begin
      req   = poke && (t == 20);
      a_vec = req ? ~a : a;
      @(negedge clk);
      t++;
    end
    req = 1'b0;
    chk("tx_complete", t < 2000, 1);
  endtask

  task automatic run_txn(input vec_t v, input bit poke);
    int d0, e0, t;
    d0 = done_cnt; e0 = err_cnt;
    start_txn(v.a, poke);
    for (int i = 0; i < v.nrsp; i++) send_byte(v.rsp[8*i +: 8], i == v.err_at, v.err_only);
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < TO + 300) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt - d0, v.exp_done);
    chk("err_pulses", err_cnt - e0, !v.exp_done);
    chk("err_code", err_code, v.exp_code);
    chk("result", result, v.exp_res);
    chk("busy_end", busy, 0);
    chk("tx_count", tx_log.size(), 3);
    if (tx_log.size() >= 3) begin
      chk("tx_hdr", tx_log[0], 8'hA5);
      chk("tx_lo", tx_log[1], v.a[7:0]);
      chk("tx_hi", tx_log[2], v.a[15:8]);
    end
    if (v.exp_done) begin
      chk("busy_with_done", busy_at_done, 1);
      chk("busy_after_done", busy_after_done, 0);
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] prev, r;
    logic [1:0]  c;
    bit          d;
    int          d0, e0, t, k, hs0;

    tbl[0] = '{16'h1234, 40'hDEADBEEF5A, 5, -1, 1'b0, 1'b1, 2'd0, 32'hDEADBEEF};
    tbl[1] = '{16'h1234, 40'h0000000000, 1, -1, 1'b0, 1'b0, 2'd3, 32'hDEADBEEF};
    tbl[2] = '{16'hBEEF, 40'h0000AA115A, 3,  2, 1'b1, 1'b0, 2'd2, 32'hDEADBEEF};
    tbl[3] = '{16'h0F0F, 40'h000000775A, 2,  1, 1'b0, 1'b0, 2'd2, 32'hDEADBEEF};
    tbl[4] = '{16'hFFFF, 40'h040302015A, 5, -1, 1'b0, 1'b1, 2'd0, 32'h04030201};
    prev = 32'h04030201;
    for (int i = 5; i < NV; i++) begin
      tbl[i].a   = 16'($urandom);
      tbl[i].rsp = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) != 0) tbl[i].rsp[7:0] = 8'h5A;
      tbl[i].err_at   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      tbl[i].err_only = 1'($urandom_range(0, 1));
      tbl[i].nrsp     = (tbl[i].rsp[7:0] != 8'h5A) ? 1 : 5;
      if (tbl[i].err_at >= 0 && tbl[i].err_at + 1 < tbl[i].nrsp) tbl[i].nrsp = tbl[i].err_at + 1;
      model(tbl[i].rsp, tbl[i].nrsp, tbl[i].err_at, prev, d, c, r);
      tbl[i].exp_done = d;
      tbl[i].exp_code = c;
      tbl[i].exp_res  = r;
      prev = r;
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_result", result, 0);
    chk("rst_err_code", err_code, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) run_txn(tbl[i], 1'b0);

    // silence after the first result byte
    d0 = done_cnt; e0 = err_cnt;
    start_txn(16'h5555, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    k = raise_cyc;
    t = 0;
    while (err_cnt == e0 && t < TO + 300) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    chk("to_err_pulse", err_cnt - e0, 1);
    chk("to_no_done", done_cnt - d0, 0);
    chk("to_code", err_code, 1);
    // event recognised one clock after the pin is sampled, error TO clocks later
    chk("to_latency", err_cyc - k, TO + 2);
    chk("to_result_held", result, prev);

    // slow transmitter plus a req while busy
    tx_hold = 50;
    hs0 = hs_viol;
    v = tbl[0];
    v.a = 16'hC3E1;
    run_txn(v, 1'b1);
    chk("hs_violations", hs_viol - hs0, 0);
    tx_hold = 3;
    repeat (60) @(negedge clk);

    // reset after two result bytes
    start_txn(16'h2468, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    chk("mrst_result", result, 0);
    chk("mrst_err_code", err_code, 0);
    d0 = done_cnt; e0 = err_cnt;
    repeat (20) @(negedge clk);
    chk("mrst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    run_txn(tbl[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
